// File: rtl/recop_led_pwm_driver.sv
// rtl/recop_led_pwm_driver.sv - LED PWM brightness and blink stage behind the LED PIO
module recop_led_pwm_driver #(
  parameter int PRESCALE = 195
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  led_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led_out
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic          enable_q, enable_d;
  logic          blink_en_q, blink_en_d;
  logic [8:0]    duty_q, duty_d;
  logic [15:0]   blink_q, blink_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [8:0]    duty_act_q, duty_act_d;
  logic [15:0]   blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    led_out_q, led_out_d;

  logic wr, wr_ctrl, tick, period_end, pwm_on;
  logic unused_wd;

  assign unused_wd = ^writedata[31:16];

  always_comb begin
    wr         = chipselect && !write_n;
    wr_ctrl    = wr && (address == 2'd0);
    tick       = (pre_cnt_q == PRE_MAX);
    period_end = tick && (pwm_cnt_q == 8'hFF);
    pwm_on     = ({1'b0, pwm_cnt_q} < duty_act_q);

    // Timebase free-runs; register writes never disturb it.
    pre_cnt_d  = tick ? '0 : pre_cnt_q + PW'(1);
    pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    duty_act_d = period_end ? duty_q : duty_act_q;

    enable_d   = enable_q;
    blink_en_d = blink_en_q;
    duty_d     = duty_q;
    blink_d    = blink_q;
    if (wr) begin
      case (address)
        2'd0:    {blink_en_d, enable_d} = writedata[1:0];
        2'd1:    duty_d = (writedata[8:0] > 9'd256) ? 9'd256 : writedata[8:0];
        2'd2:    blink_d = writedata[15:0];
        default: ;
      endcase
    end

    // Idle state is judged on the post-write config so a disable lights the LEDs at once.
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!(blink_en_d && (blink_d != 16'd0))) begin
      blink_cnt_d = 16'd0;
      phase_d     = 1'b1;
    end else if (wr_ctrl && writedata[1] && !blink_en_q) begin
      blink_cnt_d = 16'd0;
      phase_d     = 1'b1;
    end else if (period_end) begin
      if (blink_cnt_q == blink_q - 16'd1) begin
        blink_cnt_d = 16'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    led_out_d = enable_q ? (led_in & {8{pwm_on & phase_q}}) : 8'h00;

    case (address)
      2'd0:    readdata = {30'b0, blink_en_q, enable_q};
      2'd1:    readdata = {23'b0, duty_q};
      2'd2:    readdata = {16'b0, blink_q};
      default: readdata = {22'b0, phase_q, pwm_on, led_out_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q    <= 1'b1;
      blink_en_q  <= 1'b0;
      duty_q      <= 9'd256;
      blink_q     <= 16'd0;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= 8'd0;
      duty_act_q  <= 9'd256;
      blink_cnt_q <= 16'd0;
      phase_q     <= 1'b1;
      led_out_q   <= 8'h00;
    end else begin
      enable_q    <= enable_d;
      blink_en_q  <= blink_en_d;
      duty_q      <= duty_d;
      blink_q     <= blink_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_act_q  <= duty_act_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_out_q   <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_recop_led_pwm_driver.sv
// tb/tb_recop_led_pwm_driver.sv - directed self-checking bench for recop_led_pwm_driver
module tb_recop_led_pwm_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  led_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_out;

  int n_checks = 0;
  int n_fail   = 0;

  // One PWM period at PRESCALE=2 is 512 clk; the monitor below works in these windows.
  int cyc = 0;
  int acc = 0, per_on = 0, per_cnt = 0;
  logic seen_off = 1'b0, frag = 1'b0, start = 1'b0, per_frag = 1'b0, per_start = 1'b0;
  logic [31:0] rd;

  recop_led_pwm_driver #(.PRESCALE(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .led_in     (led_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Sample k reflects timebase state k-1, so samples 1..512 cover one whole period.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cyc % 512 == 1) begin
        per_on    <= acc;
        per_frag  <= frag;
        per_start <= start;
        per_cnt   <= per_cnt + 1;
        acc       <= (led_out != 8'h00) ? 1 : 0;
        start     <= (led_out != 8'h00);
        seen_off  <= (led_out == 8'h00);
        frag      <= 1'b0;
      end else begin
        acc <= acc + ((led_out != 8'h00) ? 1 : 0);
        if (led_out == 8'h00) seen_off <= 1'b1;
        if (led_out != 8'h00 && seen_off) frag <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_periods(input int n);
    int c0;
    int k;
    c0 = per_cnt;
    k  = 0;
    while (per_cnt < c0 + n && k < n * 512 + 600) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("period_wait", per_cnt - c0, n);
  endtask

  task automatic duty_case(input string tag, input logic [31:0] wval, input int exp_on);
    wait_periods(1);
    repeat (20) @(negedge clk);
    reg_write(2'd1, wval);
    wait_periods(2);
    check({tag, "_on_clk"}, per_on, exp_on);
    check({tag, "_from_step0"}, per_start, (exp_on != 0) ? 1 : 0);
    check({tag, "_contig"}, per_frag, 0);
  endtask

  initial begin
    int blink_exp[6];
    blink_exp = '{512, 512, 0, 0, 0, 512};
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    led_in = 8'hA5; reset_n = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_led_out", led_out, 8'h00);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check("pass_through", led_out, 8'hA5);
    reg_read(2'd0, rd); check("rst_ctrl", rd, 32'h1);
    reg_read(2'd1, rd); check("rst_duty", rd, 32'h100);
    reg_read(2'd2, rd); check("rst_blink", rd, 32'h0);
    reg_read(2'd3, rd); check("rst_phase", rd[9], 1'b1);
    check("rst_status_led", rd[7:0], 8'hA5);

    led_in = 8'hFF;
    duty_case("duty64", 32'd64, 128);
    duty_case("duty0", 32'd0, 0);
    duty_case("duty_sat", 32'h1FF, 512);
    reg_read(2'd1, rd); check("duty_sat_read", rd, 32'h100);

    duty_case("glitch_pre", 32'd64, 128);
    repeat (100) @(negedge clk);
    reg_write(2'd1, 32'd200);
    wait_periods(1);
    check("glitch_cur_period", per_on, 128);
    wait_periods(1);
    check("glitch_next_period", per_on, 400);

    duty_case("duty256", 32'd256, 512);
    wait_periods(1);
    repeat (10) @(negedge clk);
    reg_write(2'd2, 32'd3);
    reg_write(2'd0, 32'h3);
    wait_periods(1);
    check("blink_start_win", per_on, 512);
    for (int i = 0; i < 6; i++) begin
      wait_periods(1);
      check($sformatf("blink_win%0d", i), per_on, blink_exp[i]);
      if (i == 2) begin
        reg_read(2'd3, rd);
        check("blink_off_phase", rd[9], 1'b0);
      end
    end
    wait_periods(2);
    repeat (5) @(negedge clk);
    check("blink_off_led", led_out, 8'h00);
    reg_write(2'd0, 32'h1);
    reg_read(2'd3, rd);
    check("unblink_phase", rd[9], 1'b1);
    @(negedge clk);
    check("unblink_led", led_out, 8'hFF);

    reg_write(2'd0, 32'h0);
    led_in = 8'h55;
    repeat (2) @(negedge clk);
    check("disabled_55", led_out, 8'h00);
    led_in = 8'hAA;
    @(negedge clk);
    check("disabled_aa", led_out, 8'h00);
    led_in = 8'h3C;
    reg_write(2'd0, 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("enable_3c", led_out, 8'h3C);
    reg_write(2'd3, 32'hFFFF_FFFF);
    reg_read(2'd0, rd); check("status_wr_ctrl", rd, 32'h1);
    reg_read(2'd1, rd); check("status_wr_duty", rd, 32'h100);
    reg_read(2'd2, rd); check("status_wr_blink", rd, 32'h3);
    check("status_wr_led", led_out, 8'h3C);

    led_in = 8'hFF;
    wait_periods(1);
    repeat (10) @(negedge clk);
    reg_write(2'd0, 32'h3);
    wait_periods(3);
    repeat (20) @(negedge clk);
    reg_read(2'd3, rd);
    check("pre_reset_off", rd[9], 1'b0);
    #2 reset_n = 1'b0;
    #1 check("reset_led_now", led_out, 8'h00);
    address = 2'd0; #1 check("reset_ctrl", readdata, 32'h1);
    address = 2'd1; #1 check("reset_duty", readdata, 32'h100);
    address = 2'd2; #1 check("reset_blink", readdata, 32'h0);
    address = 2'd3; #1 check("reset_phase", readdata[9], 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    led_in  = 8'h5A;
    @(negedge clk);
    check("post_reset_pass", led_out, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
